// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: request bundle and response-owner encoding.
// The request struct is sized for the default 32-bit datapath.
package dmem_arb_pkg;

    localparam int unsigned DW = 32;
    localparam int unsigned MW = DW / 8;

    typedef enum logic {
        OWNER_CORE = 1'b0,
        OWNER_EXT  = 1'b1
    } owner_e;

    typedef struct packed {
        logic          we;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [MW-1:0] mask;
    } mem_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; req/gnt bit 0 is the core, bit 1 the external port.
// Grant is combinational; last_gnt only moves on cycles that actually grant.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    owner_e last_gnt;

    always_comb begin
        gnt = '0;
        if (req[0] && req[1]) begin
            if (last_gnt == OWNER_EXT) begin
                gnt = 2'b01;
            end else begin
                gnt = 2'b10;
            end
        end else begin
            gnt = req;
        end
    end

    // Reset to EXT so the core wins the first conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= OWNER_EXT;
        end else if (gnt[0]) begin
            last_gnt <= OWNER_CORE;
        end else if (gnt[1]) begin
            last_gnt <= OWNER_EXT;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single dmem between the LSU and an external requester: one access per
// cycle, round-robin on conflict, 1-cycle read response routed back to its owner.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 32,
    localparam int unsigned MASK_SIZE  = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [DATA_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    input  logic [MASK_SIZE-1:0]  core_mask,
    output logic                  core_gnt,
    output logic                  core_rvalid,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  core_stall,

    input  logic                  ext_req,
    input  logic                  ext_we,
    input  logic [DATA_WIDTH-1:0] ext_addr,
    input  logic [DATA_WIDTH-1:0] ext_wdata,
    input  logic [MASK_SIZE-1:0]  ext_mask,
    output logic                  ext_gnt,
    output logic                  ext_rvalid,
    output logic [DATA_WIDTH-1:0] ext_rdata,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [MASK_SIZE-1:0]  mem_mask,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    logic [1:0] req;
    logic [1:0] gnt;
    mem_req_t   core_r;
    mem_req_t   ext_r;
    mem_req_t   sel_r;
    owner_e     rsp_owner;
    logic       rsp_pending;
    logic       load_issue;

    assign req = {ext_req, core_req};

    rr_arb2 u_rr_arb2 (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    assign core_gnt   = gnt[0];
    assign ext_gnt    = gnt[1];
    assign core_stall = core_req & ~gnt[0];

    always_comb begin
        core_r.we    = core_we;
        core_r.addr  = core_addr;
        core_r.wdata = core_wdata;
        core_r.mask  = core_mask;
        ext_r.we     = ext_we;
        ext_r.addr   = ext_addr;
        ext_r.wdata  = ext_wdata;
        ext_r.mask   = ext_mask;
    end

    always_comb begin
        sel_r = core_r;
        if (gnt[1]) begin
            sel_r = ext_r;
        end
    end

    // Control fields are forced to zero when idle so dmem never sees a stray write.
    always_comb begin
        mem_en    = |gnt;
        mem_we    = mem_en & sel_r.we;
        mem_addr  = mem_en ? sel_r.addr : '0;
        mem_mask  = mem_en ? sel_r.mask : '0;
        mem_wdata = sel_r.wdata;
    end

    assign load_issue = mem_en & ~sel_r.we;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_pending <= 1'b0;
            rsp_owner   <= OWNER_CORE;
        end else begin
            rsp_pending <= load_issue;
            if (load_issue) begin
                rsp_owner <= gnt[1] ? OWNER_EXT : OWNER_CORE;
            end
        end
    end

    // rvalid is held low while reset is asserted, discarding any in-flight load.
    always_comb begin
        core_rvalid = rsp_pending & ~rst & (rsp_owner == OWNER_CORE);
        ext_rvalid  = rsp_pending & ~rst & (rsp_owner == OWNER_EXT);
        core_rdata  = mem_rdata;
        ext_rdata   = mem_rdata;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a behavioural dmem drives mem_rdata, a reference
// model predicts grants and load data, and a monitor checks every response cycle.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_req = 1'b0, core_we = 1'b0;
    logic [31:0] core_addr = '0, core_wdata = '0;
    logic [3:0]  core_mask = '0;
    logic        core_gnt, core_rvalid, core_stall;
    logic [31:0] core_rdata;
    logic        ext_req = 1'b0, ext_we = 1'b0;
    logic [31:0] ext_addr = '0, ext_wdata = '0;
    logic [3:0]  ext_mask = '0;
    logic        ext_gnt, ext_rvalid;
    logic [31:0] ext_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_mask;
    logic [31:0] mem_rdata;

    dmem_arbiter #(.DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_mask   (core_mask),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .core_stall  (core_stall),
        .ext_req     (ext_req),
        .ext_we      (ext_we),
        .ext_addr    (ext_addr),
        .ext_wdata   (ext_wdata),
        .ext_mask    (ext_mask),
        .ext_gnt     (ext_gnt),
        .ext_rvalid  (ext_rvalid),
        .ext_rdata   (ext_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_mask    (mem_mask),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'hDEADBEEF;
        if (i == 8) return 32'hAAAAAAAA;
        return 32'h1000_0000 + 32'h0101_0101 * 32'(i);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // Behavioural dmem: one access per cycle, read data registered.
    logic [31:0] dmem_q [64];
    bit          init_done = 1'b0;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 64; i++) dmem_q[i] <= init_word(i);
            init_done <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_mask[b]) dmem_q[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= dmem_q[mem_addr[7:2]];
            end
        end
    end

    typedef struct {
        bit          owner;
        logic [31:0] data;
    } rsp_t;

    logic [31:0] ref_mem [64];
    bit          ref_last;
    rsp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    logic        c_req, c_we, e_req, e_we;
    logic [31:0] c_addr, c_wdata, e_addr, e_wdata;
    logic [3:0]  c_mask, e_mask;
    bit          g_core, g_ext;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check the combinational response, advance the model.
    task automatic step(input bit r);
        bit          ec, ee, sw;
        logic [31:0] sa, sd;
        logic [3:0]  sm;
        @(posedge clk);
        #1;
        rst        = r;
        core_req   = c_req;  core_we  = c_we;  core_addr = c_addr;
        core_wdata = c_wdata; core_mask = c_mask;
        ext_req    = e_req;  ext_we   = e_we;  ext_addr  = e_addr;
        ext_wdata  = e_wdata; ext_mask  = e_mask;
        #2;
        ec = c_req && (!e_req || ref_last);
        ee = e_req && !ec;
        chk("core_gnt", core_gnt, ec);
        chk("ext_gnt", ext_gnt, ee);
        chk("core_stall", core_stall, c_req && !ec);
        chk("mem_en", mem_en, ec || ee);
        if (ec) begin
            sw = c_we; sa = c_addr; sd = c_wdata; sm = c_mask;
        end else begin
            sw = e_we; sa = e_addr; sd = e_wdata; sm = e_mask;
        end
        if (ec || ee) begin
            chk("mem_we", mem_we, sw);
            chk("mem_addr", mem_addr, sa);
            chk("mem_mask", mem_mask, sm);
            if (sw) chk("mem_wdata", mem_wdata, sd);
            if (sw) ref_mem[sa[7:2]] = merge(ref_mem[sa[7:2]], sd, sm);
            else if (!r) exp_q.push_back('{ee, ref_mem[sa[7:2]]});
        end else begin
            chk("idle_mem_we", mem_we, 0);
            chk("idle_mem_mask", mem_mask, 0);
            chk("idle_mem_addr", mem_addr, 0);
        end
        if (r) ref_last = 1'b1;
        else if (ec || ee) ref_last = ee;
        g_core = ec;
        g_ext  = ee;
    endtask

    // Monitor: a load granted last cycle must show exactly one rvalid with its data now.
    initial begin
        forever begin
            rsp_t e;
            bit   ev;
            e  = '{0, 32'h0};
            ev = 1'b0;
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                ev = !rst;
            end
            chk("core_rvalid", core_rvalid, ev && !e.owner);
            chk("ext_rvalid", ext_rvalid, ev && e.owner);
            if (ev && !e.owner) chk("core_rdata", core_rdata, e.data);
            if (ev && e.owner) chk("ext_rdata", ext_rdata, e.data);
        end
    end

    task automatic set_idle();
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0; c_mask = '0;
        e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_mask = '0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        ref_last = 1'b1;
        set_idle();
        step(1);
        step(1);

        // Single core load from 0x10
        c_req = 1; c_we = 0; c_addr = 32'h10; c_mask = 4'hF;
        step(0);
        chk("tp1_core_gnt", core_gnt, 1);
        c_req = 0;
        step(0);
        chk("tp1_core_rdata", core_rdata, 32'hDEADBEEF);
        chk("tp1_ext_rvalid", ext_rvalid, 0);

        // First conflict after reset goes to the core, then alternation
        step(1);
        c_req = 1; c_we = 0; c_addr = 32'h10; c_mask = 4'hF;
        e_req = 1; e_we = 0; e_addr = 32'h14; e_mask = 4'hF;
        step(0);
        chk("tp2_core_first", core_gnt, 1);
        chk("tp2_no_stall", core_stall, 0);
        for (int i = 0; i < 6; i++) begin
            if (g_core) c_addr = (c_addr + 32'h8) & 32'hFC;
            if (g_ext)  e_addr = (e_addr + 32'h8) & 32'hFC;
            step(0);
            chk("tp3_alternate", ext_gnt, (i % 2) == 0);
        end

        // Partial ext store then core load of the same word
        set_idle();
        e_req = 1; e_we = 1; e_addr = 32'h20; e_wdata = 32'h12345678; e_mask = 4'b0011;
        step(0);
        set_idle();
        c_req = 1; c_we = 0; c_addr = 32'h20; c_mask = 4'hF;
        step(0);
        set_idle();
        step(0);
        chk("tp4_merge_valid", core_rvalid, 1);
        chk("tp4_merge_data", core_rdata, 32'hAAAA5678);

        // Reset right after a load grant discards the response
        c_req = 1; c_we = 0; c_addr = 32'h10; c_mask = 4'hF;
        step(0);
        set_idle();
        step(1);
        chk("tp5_rvalid_in_reset", core_rvalid, 0);
        step(0);
        chk("tp5_rvalid_after", core_rvalid, 0);
        c_req = 1; c_addr = 32'h18; c_mask = 4'hF;
        e_req = 1; e_addr = 32'h1C; e_mask = 4'hF;
        step(0);
        chk("tp5_core_first", core_gnt, 1);

        // Idle
        set_idle();
        repeat (3) begin
            step(0);
            chk("tp6_idle_en", mem_en, 0);
        end

        // Randomized traffic; refused requests hold their fields until granted
        repeat (400) begin
            if (!(c_req && !g_core)) begin
                c_req   = ($urandom_range(0, 3) != 0);
                c_we    = $urandom_range(0, 1);
                c_addr  = 32'($urandom_range(0, 63)) << 2;
                c_wdata = $urandom;
                c_mask  = 4'($urandom_range(0, 15));
            end
            if (!(e_req && !g_ext)) begin
                e_req   = ($urandom_range(0, 3) != 0);
                e_we    = $urandom_range(0, 1);
                e_addr  = 32'($urandom_range(0, 63)) << 2;
                e_wdata = $urandom;
                e_mask  = 4'($urandom_range(0, 15));
            end
            step($urandom_range(0, 63) == 0);
        end

        set_idle();
        step(0);
        step(0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port round-robin arbiter that shares the single data memory between the core's memory stage (LSU side) and an external requester (debug/DMA port). It sits between the LSU and `dmem`, grants at most one access per cycle, routes the 1-cycle read response back to its owner, and generates the core stall. It replaces the direct LSU-to-`dmem` connection; the LSU still produces address, store data and byte mask.

## Interface
- `DATA_WIDTH`, 32, data and address width
- `MASK_SIZE` (localparam), `DATA_WIDTH/8`, byte-mask width
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `core_req` / `ext_req`  in  1  access request, held until granted
- `core_we` / `ext_we`  in  1  1 = store, 0 = load
- `core_addr` / `ext_addr`  in  DATA_WIDTH  byte address
- `core_wdata` / `ext_wdata`  in  DATA_WIDTH  store data, lane-aligned
- `core_mask` / `ext_mask`  in  MASK_SIZE  byte enables
- `core_gnt` / `ext_gnt`  out  1  combinational grant, same cycle as request
- `core_rvalid` / `ext_rvalid`  out  1  load data valid, 1 cycle after a load grant
- `core_rdata` / `ext_rdata`  out  DATA_WIDTH  load data; both driven from `mem_rdata`
- `core_stall`  out  1  `core_req & ~core_gnt`
- `mem_en`  out  1  access issued this cycle
- `mem_we`  out  1  `dmem` write enable
- `mem_addr`, `mem_wdata`  out  DATA_WIDTH  selected request fields
- `mem_mask`  out  MASK_SIZE  selected byte enables
- `mem_rdata`  in  DATA_WIDTH  `dmem` read data, valid the cycle after a read issue

## Operation
- Grant: if only one `*_req` is high, that requester wins. If both are high, the winner is the requester not granted last (`last_gnt` register, 0 = core, 1 = ext). `last_gnt` updates only on cycles where a grant occurs.
- Exactly one of `core_gnt` and `ext_gnt` is high when any request is high, and neither is high otherwise. `mem_en = core_gnt | ext_gnt`.
- When idle (`mem_en` = 0), `mem_we`, `mem_mask` and `mem_addr` are 0, so no spurious write can occur. `mem_wdata` is don't-care when idle.
- Response owner register `rsp_owner`, plus a `rsp_pending` flag. Both are set on a load grant (`we` = 0), and the flag is cleared otherwise. A store grant never produces an `rvalid`; the store completes at its grant edge.
- `core_rvalid = rsp_pending & ~rsp_owner`, `ext_rvalid = rsp_pending & rsp_owner`.
- Back-to-back: a new grant is legal in the same cycle a response returns; `dmem` is fully pipelined at 1 access per cycle.
- A requester whose request is refused must hold all its fields stable until granted. A dropped request is legal and simply takes no grant.
- Reset asserted mid-operation: `last_gnt` returns to 1, so core wins the first conflict after reset. `rsp_pending` returns to 0, and a load issued in the reset cycle's prior edge has its response discarded (no `rvalid`).

## Timing
- Reset values: `last_gnt` = 1, `rsp_pending` = 0, `rsp_owner` = 0. As a result, all `rvalid` outputs are 0 during and after reset until a new load is granted.
- Grant latency: 0 cycles, combinational from `*_req` and `last_gnt`.
- Load latency: grant in cycle N, `rvalid` and `rdata` in cycle N+1, for exactly 1 cycle.
- Store latency: written at the end of cycle N.
- Fairness: under continuous dual requests, grants alternate ext, core, ext, core… Worst-case core wait is 1 cycle.
- `core_stall` is combinational and must not depend on `mem_rdata`. There is no combinational path from `mem_rdata` to any grant.

## Structure
- Package `dmem_arb_pkg`:
  - `mem_req_t` struct: `we`, `addr`, `wdata`, `mask`
  - `owner_e` enum: `OWNER_CORE`=0, `OWNER_EXT`=1
- Sub-module `rr_arb2`: 2-input round-robin arbiter holding `last_gnt` and producing the one-hot grant. The top level does request muxing, response routing and stall.
- The core memory stage instantiates `dmem_arbiter` in place of the direct `dmem` hookup and drives pipeline stall from `core_stall`.

## Test plan
- Reset then single core load: `core_req`=1, `we`=0, `addr`=0x10, memory holds 0xDEADBEEF → `core_gnt`=1 in the same cycle, next cycle `core_rvalid`=1 with `core_rdata`=0xDEADBEEF, and `ext_rvalid`=0.
- Simultaneous first conflict after reset: both load → core granted and `ext_gnt`=0, `core_stall`=0. Next cycle ext granted and `core_stall`=1 if core still requests.
- Sustained dual requests for 6 cycles → grant order ext, core, ext, core… after the first core win. `rvalid` toggles owner each cycle with matching data.
- Ext store `addr`=0x20, `wdata`=0x12345678, `mask`=4'b0011, then core load 0x20 with prior contents 0xAAAAAAAA → core reads 0xAAAA5678, and no `rvalid` on the store.
- Reset asserted the cycle after a core load grant → `core_rvalid` stays 0, and after release a conflict grants core first.
- Idle cycles: no requests → `mem_en`=0, `mem_we`=0, `mem_mask`=0, both `gnt`=0, `core_stall`=0.
